strb_checker: RTL and testbench
===============================

# strb_checker

Strobe result checker that sits directly downstream of the DQ strobe sampler. It consumes each sampler result (data, valid, and an event marker), pops a matching expected byte and mask from a local expected-data FIFO, and compares them. It keeps compare and fail counts, captures the first failure, and reports PASS/DONE status to the test sequencer through a small run/stop state machine.

## Interface
- `DEPTH`, default 8: expected-FIFO entries. Power of two, range 2..32.
- `CLK`  in  1  clock; all logic is on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  1-cycle pulse; clears counters and captures, then enters RUN.
- `STOP`  in  1  1-cycle pulse; RUN -> DONE.
- `EXP_WR`  in  1  push an expected entry.
- `EXP_DATA`  in  8  expected byte.
- `EXP_MASK`  in  8  compare mask; 1 = bit is checked.
- `EXP_FULL`  out  1  FIFO full.
- `EXP_LEVEL`  out  6  FIFO occupancy, 0..DEPTH.
- `SMP_EVENT`  in  1  the sampler produced a result this cycle. Aligned with the sampler output register. Asserted even when `SMP_VALID`=0.
- `SMP_DATA`  in  8  sampled byte.
- `SMP_VALID`  in  1  sampled DQ was valid.
- `BUSY`  out  1  state == RUN.
- `DONE`  out  1  state == DONE.
- `PASS`  out  1  DONE, and `FAIL_CNT`==0, and no sticky error.
- `CMP_CNT`  out  16  compares performed; saturates at 0xFFFF.
- `FAIL_CNT`  out  16  failed compares; saturates at 0xFFFF.
- `FIRST_FAIL_IDX`  out  16  value of `CMP_CNT` at the first failure.
- `FIRST_FAIL_DATA`  out  8  `SMP_DATA` at the first failure.
- `FIRST_FAIL_EXP`  out  8  expected byte at the first failure.
- `UNDERRUN`  out  1  sticky: an event arrived while the FIFO was empty.
- `OVERFLOW`  out  1  sticky: a push was attempted while the FIFO was full.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on `START`.
  - RUN -> DONE on `STOP`.
  - DONE -> RUN on `START`.
  - `STOP` in IDLE or DONE is ignored.
- `START` clears: both counters, the first-fail captures, `UNDERRUN`, and `OVERFLOW`. It does not flush the FIFO.
- FIFO push:
  - Push is accepted in any state when not full.
  - A push while full is dropped and sets `OVERFLOW`, even if a pop happens in the same cycle.
- Events outside RUN are ignored: no pop and no count.
- On `SMP_EVENT` in RUN with the FIFO non-empty:
  - Pop one entry and increment `CMP_CNT`.
  - Fail if `((SMP_DATA ^ exp) & mask) != 0`.
  - Also fail if `SMP_VALID`=0 and `mask` != 0.
  - `mask`=0 always passes.
- On `SMP_EVENT` in RUN with the FIFO empty:
  - Set `UNDERRUN`. No pop, no compare, no count.
  - A push in the same cycle is not bypassed to this event; it is simply stored.
- First failure only, while `FAIL_CNT`==0:
  - `FIRST_FAIL_IDX` takes the pre-increment `CMP_CNT`.
  - `FIRST_FAIL_DATA` and `FIRST_FAIL_EXP` are loaded.
- `START` and `SMP_EVENT` in the same cycle: `START` wins; the event is ignored.
- `STOP` and `SMP_EVENT` in the same cycle: the event is compared, then the state moves to DONE.

## Timing
- Reset values:
  - state IDLE; all counts 0.
  - `EXP_FULL`=0, `EXP_LEVEL`=0.
  - `BUSY`, `DONE`, `PASS`, `UNDERRUN`, `OVERFLOW` = 0.
  - All capture registers 0.
- Reset asserted mid-run discards the FIFO contents and all state.
- The compare result is registered. Counters, captures and sticky flags update 1 cycle after `SMP_EVENT`.
- Back-to-back events every cycle are supported at full rate.
- `EXP_LEVEL` and `EXP_FULL` reflect pushes and pops on the following cycle.
- A simultaneous push and pop leaves the level unchanged.
- `BUSY`, `DONE` and `PASS` are registered: they change 1 cycle after `START`/`STOP`.
- `PASS` accounts for an event compared in the same cycle as `STOP`.
- FIFO pointers are log2(`DEPTH`) bits and wrap; occupancy is tracked in a separate counter.

## Configuration
- `STRB_CHECKER_STOP_ON_FAIL_EN` defined:
  - The first failing compare in RUN forces RUN -> DONE on the next cycle.
  - Later events are ignored, so `FAIL_CNT` stops at 1.
- Not defined: RUN continues through failures until `STOP`.

## Test plan
- Full pass: reset, push 4 entries (0xA5/0xFF, 0x3C/0xFF, 0x00/0xFF, 0xFF/0xFF), `START`, 4 matching events, `STOP` -> `CMP_CNT`=4, `FAIL_CNT`=0, `PASS`=1, `EXP_LEVEL`=0.
- Mask and invalid:
  - Push 0xF0/0xF0, event 0xF7 valid -> pass.
  - Push 0x00/0x01, event `SMP_VALID`=0 -> fail; `FIRST_FAIL_IDX`=1, `FIRST_FAIL_EXP`=0x00.
  - Push 0x00/0x00, event invalid -> pass.
- Underrun: `START` with an empty FIFO, event 0x12 -> `UNDERRUN`=1, `CMP_CNT`=0; after `STOP`, `PASS`=0.
- Overflow and wrap: with `DEPTH`=8, push 9 entries -> `OVERFLOW`=1, `EXP_LEVEL`=8. Then do 20 interleaved push/pop cycles -> data order is preserved across the pointer wrap.
- Collisions:
  - `START` with an event in the same cycle -> `CMP_CNT` stays 0.
  - `STOP` with a failing event in the same cycle -> `FAIL_CNT`=1, `DONE`=1, `PASS`=0.
- Stop-on-fail, with `STRB_CHECKER_STOP_ON_FAIL_EN` defined: 3 entries, the second mismatches -> `DONE`=1 after event 2, event 3 ignored, `CMP_CNT`=2, `FAIL_CNT`=1.

Source files
------------

// File: rtl/strb_checker.sv
// strb_checker: compares DQ sampler results against an expected-data FIFO, with counters, first-fail capture and run status.
// Optional STRB_CHECKER_STOP_ON_FAIL_EN ends the run at the first failing compare.
module strb_checker #(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        STOP,
  input  logic        EXP_WR,
  input  logic [7:0]  EXP_DATA,
  input  logic [7:0]  EXP_MASK,
  output logic        EXP_FULL,
  output logic [5:0]  EXP_LEVEL,
  input  logic        SMP_EVENT,
  input  logic [7:0]  SMP_DATA,
  input  logic        SMP_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] CMP_CNT,
  output logic [15:0] FAIL_CNT,
  output logic [15:0] FIRST_FAIL_IDX,
  output logic [7:0]  FIRST_FAIL_DATA,
  output logic [7:0]  FIRST_FAIL_EXP,
  output logic        UNDERRUN,
  output logic        OVERFLOW
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nx;
  logic [7:0] mem_data [DEPTH];
  logic [7:0] mem_mask [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [5:0] level;
  logic push, ev, pop, fail, stop_fail;
  logic [7:0] exp_data, exp_mask;
  assign EXP_FULL = level == 6'(DEPTH);
  assign EXP_LEVEL = level;
  assign BUSY = state == RUN;
  assign DONE = state == FIN;
  assign PASS = DONE && FAIL_CNT == 16'd0 && !UNDERRUN && !OVERFLOW;
  assign push = EXP_WR && !EXP_FULL;
  assign ev = SMP_EVENT && state == RUN && !START;
  assign pop = ev && level != 6'd0;
  assign exp_data = mem_data[rd_ptr];
  assign exp_mask = mem_mask[rd_ptr];
  // An invalid sample can only pass when no bit is checked.
  assign fail = pop && ((|((SMP_DATA ^ exp_data) & exp_mask)) || (!SMP_VALID && |exp_mask));
`ifdef STRB_CHECKER_STOP_ON_FAIL_EN
  assign stop_fail = fail;
`else
  assign stop_fail = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = START ? RUN : (state == RUN && (STOP || stop_fail)) ? FIN : state;
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wr_ptr] <= EXP_DATA;
      mem_mask[wr_ptr] <= EXP_MASK;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      CMP_CNT         <= '0;
      FAIL_CNT        <= '0;
      FIRST_FAIL_IDX  <= '0;
      FIRST_FAIL_DATA <= '0;
      FIRST_FAIL_EXP  <= '0;
      UNDERRUN        <= 1'b0;
      OVERFLOW        <= 1'b0;
    end else begin
      state  <= state_nx;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      level  <= level + 6'(push) - 6'(pop);
      if (START) begin
        CMP_CNT         <= '0;
        FAIL_CNT        <= '0;
        FIRST_FAIL_IDX  <= '0;
        FIRST_FAIL_DATA <= '0;
        FIRST_FAIL_EXP  <= '0;
        UNDERRUN        <= 1'b0;
        OVERFLOW        <= 1'b0;
      end else begin
        UNDERRUN <= UNDERRUN | (ev && level == 6'd0);
        OVERFLOW <= OVERFLOW | (EXP_WR && EXP_FULL);
        if (pop) CMP_CNT <= CMP_CNT + 16'(CMP_CNT != 16'hFFFF);
        if (fail) FAIL_CNT <= FAIL_CNT + 16'(FAIL_CNT != 16'hFFFF);
        if (fail && FAIL_CNT == 16'd0) begin
          FIRST_FAIL_IDX  <= CMP_CNT;
          FIRST_FAIL_DATA <= SMP_DATA;
          FIRST_FAIL_EXP  <= exp_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_strb_checker.sv
// tb_strb_checker: directed test-plan steps plus a randomized run, checked every cycle against a queue-based reference model.
module tb_strb_checker;
  localparam int DEPTH = 8;
`ifdef STRB_CHECKER_STOP_ON_FAIL_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif
  logic CLK = 1'b0, RST_N = 1'b0;
  logic START = 0, STOP = 0, EXP_WR = 0, SMP_EVENT = 0, SMP_VALID = 0;
  logic [7:0] EXP_DATA = 0, EXP_MASK = 0, SMP_DATA = 0;
  logic EXP_FULL, BUSY, DONE, PASS, UNDERRUN, OVERFLOW;
  logic [5:0] EXP_LEVEL;
  logic [15:0] CMP_CNT, FAIL_CNT, FIRST_FAIL_IDX;
  logic [7:0] FIRST_FAIL_DATA, FIRST_FAIL_EXP;

  strb_checker #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP),
    .EXP_WR(EXP_WR), .EXP_DATA(EXP_DATA), .EXP_MASK(EXP_MASK),
    .EXP_FULL(EXP_FULL), .EXP_LEVEL(EXP_LEVEL),
    .SMP_EVENT(SMP_EVENT), .SMP_DATA(SMP_DATA), .SMP_VALID(SMP_VALID),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .CMP_CNT(CMP_CNT), .FAIL_CNT(FAIL_CNT), .FIRST_FAIL_IDX(FIRST_FAIL_IDX),
    .FIRST_FAIL_DATA(FIRST_FAIL_DATA), .FIRST_FAIL_EXP(FIRST_FAIL_EXP),
    .UNDERRUN(UNDERRUN), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [7:0] d; logic [7:0] m;} ent_t;
  ent_t q[$];
  int m_st, m_cmp, m_fail, m_ffi;
  logic [7:0] m_ffd, m_ffe;
  bit m_und, m_ovf;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_cmp = 0; m_fail = 0; m_ffi = 0; m_ffd = 0; m_ffe = 0; m_und = 0; m_ovf = 0;
  endtask

  // One clock of the reference behaviour, using the inputs present at the edge.
  task automatic model_step(input bit st, sp, wr, input logic [7:0] ed, em,
                            input bit ev, input logic [7:0] sd, input bit sv);
    bit full, take, bad;
    ent_t e;
    full = q.size() == DEPTH;
    take = ev && m_st == 1 && !st;
    bad = 0;
    if (take && q.size() == 0) m_und = 1;
    if (take && q.size() > 0) begin
      e = q.pop_front();
      bad = ((sd ^ e.d) & e.m) != 8'd0 || (!sv && e.m != 8'd0);
      if (bad && m_fail == 0) begin m_ffi = m_cmp; m_ffd = sd; m_ffe = e.d; end
      if (m_cmp < 65535) m_cmp++;
      if (bad && m_fail < 65535) m_fail++;
    end
    if (wr) begin
      if (full) m_ovf = 1;
      else q.push_back('{ed, em});
    end
    if (st) begin model_clear(); m_st = 1; end
    else if (m_st == 1 && (sp || (SOF && bad))) m_st = 2;
  endtask

  task automatic check_all();
    chk("busy", BUSY, m_st == 1);
    chk("done", DONE, m_st == 2);
    chk("pass", PASS, m_st == 2 && m_fail == 0 && !m_und && !m_ovf);
    chk("cmp_cnt", CMP_CNT, m_cmp);
    chk("fail_cnt", FAIL_CNT, m_fail);
    chk("ff_idx", FIRST_FAIL_IDX, m_ffi);
    chk("ff_data", FIRST_FAIL_DATA, m_ffd);
    chk("ff_exp", FIRST_FAIL_EXP, m_ffe);
    chk("underrun", UNDERRUN, m_und);
    chk("overflow", OVERFLOW, m_ovf);
    chk("level", EXP_LEVEL, q.size());
    chk("full", EXP_FULL, q.size() == DEPTH);
  endtask

  task automatic cyc(input bit st, sp, wr, input logic [7:0] ed, em,
                     input bit ev, input logic [7:0] sd, input bit sv);
    @(negedge CLK);
    START = st; STOP = sp; EXP_WR = wr; EXP_DATA = ed; EXP_MASK = em;
    SMP_EVENT = ev; SMP_DATA = sd; SMP_VALID = sv;
    @(posedge CLK);
    model_step(st, sp, wr, ed, em, ev, sd, sv);
    #1 check_all();
  endtask

  task automatic push(input logic [7:0] d, m);
    cyc(0, 0, 1, d, m, 0, 8'h00, 0);
  endtask

  task automatic event_in(input logic [7:0] d, input bit v);
    cyc(0, 0, 0, 8'h00, 8'h00, 1, d, v);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    START = 0; STOP = 0; EXP_WR = 0; SMP_EVENT = 0; SMP_VALID = 0;
    EXP_DATA = 0; EXP_MASK = 0; SMP_DATA = 0;
    RST_N = 0;
    q.delete(); m_st = 0; model_clear();
    #1 check_all();
    @(negedge CLK) RST_N = 1;
  endtask

  initial begin
    logic [7:0] f, r;
    int k;
    do_reset();
    chk("rst_level", EXP_LEVEL, 0);
    chk("rst_pass", PASS, 0);
    // full pass
    push(8'hA5, 8'hFF); push(8'h3C, 8'hFF); push(8'h00, 8'hFF); push(8'hFF, 8'hFF);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    event_in(8'hA5, 1); event_in(8'h3C, 1); event_in(8'h00, 1); event_in(8'hFF, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("tp_full_cmp", CMP_CNT, 4);
    chk("tp_full_fail", FAIL_CNT, 0);
    chk("tp_full_pass", PASS, 1);
    chk("tp_full_level", EXP_LEVEL, 0);
    // mask and invalid sample
    do_reset();
    push(8'hF0, 8'hF0); push(8'h00, 8'h01); push(8'h00, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    event_in(8'hF7, 1);
    chk("tp_mask_pass", FAIL_CNT, 0);
    event_in(8'h00, 0);
    chk("tp_inv_fail", FAIL_CNT, 1);
    chk("tp_inv_idx", FIRST_FAIL_IDX, 1);
    chk("tp_inv_exp", FIRST_FAIL_EXP, 8'h00);
    event_in(8'h5A, 0);
    chk("tp_mask0_fail", FAIL_CNT, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    // underrun
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    event_in(8'h12, 1);
    chk("tp_und_flag", UNDERRUN, 1);
    chk("tp_und_cmp", CMP_CNT, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("tp_und_pass", PASS, 0);
    chk("tp_und_done", DONE, 1);
    // overflow, then order across the pointer wrap
    do_reset();
    for (int i = 0; i < 9; i++) push(8'(i * 17 + 3), 8'hFF);
    chk("tp_ovf_flag", OVERFLOW, 1);
    chk("tp_ovf_level", EXP_LEVEL, 8);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    event_in(q[0].d, 1);
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom);
      cyc(0, 0, 1, r, 8'hFF, 1, q[0].d, 1);
    end
    chk("tp_wrap_cmp", CMP_CNT, 21);
    chk("tp_wrap_fail", FAIL_CNT, 0);
    chk("tp_wrap_level", EXP_LEVEL, 7);
    // collisions
    do_reset();
    push(8'h55, 8'hFF);
    cyc(1, 0, 0, 0, 0, 1, 8'h55, 1);
    chk("tp_col_start_cmp", CMP_CNT, 0);
    chk("tp_col_start_lvl", EXP_LEVEL, 1);
    cyc(0, 1, 0, 0, 0, 1, 8'hAA, 1);
    chk("tp_col_stop_fail", FAIL_CNT, 1);
    chk("tp_col_stop_done", DONE, 1);
    chk("tp_col_stop_pass", PASS, 0);
    if (SOF) begin
      do_reset();
      push(8'h11, 8'hFF); push(8'h22, 8'hFF); push(8'h33, 8'hFF);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      event_in(8'h11, 1);
      event_in(8'h99, 1);
      chk("tp_sof_done", DONE, 1);
      event_in(8'h33, 1);
      chk("tp_sof_cmp", CMP_CNT, 2);
      chk("tp_sof_fail", FAIL_CNT, 1);
    end
    // randomized traffic
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 3));
      f = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].d : 8'($urandom);
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
          8'($urandom), k == 0 ? 8'h00 : k == 1 ? 8'($urandom) : 8'hFF,
          $urandom_range(0, 1) == 1, f, $urandom_range(0, 7) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
